ternary_neuron_seq: RTL and testbench

Sequential ternary-neuron back end that consumes approximate 25-input popcount results. Each input beat carries two 5-bit popcounts, one per popcount stage instance: positive-weight matches and negative-weight matches. The block accumulates their signed difference over a variable number of beats, then applies two programmable thresholds to emit a ternary activation (+1/0/-1) through a valid/ready handshake. It sits directly downstream of the popcount stage in the printed-neuron datapath.

---
 rtl/ternary_neuron_seq_if.sv | 37 +++
 rtl/ternary_neuron_seq.sv | 176 +++++++++++++++++
 tb/tb_ternary_neuron_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ternary_neuron_seq_if.sv
// ---------------------------------------------------------------------------
// ternary_neuron_seq_if
// Bus bundle between the popcount stage and the ternary-neuron back end.
//   in_valid / in_ready        : beat handshake (producer -> neuron)
//   in_pc_pos / in_pc_neg      : 5-bit unsigned popcounts of one beat
//   in_last                    : final beat of the current neuron
//   thr_hi / thr_lo            : signed activation thresholds (ACC_W bits)
//   out_valid / out_ready      : result handshake (neuron -> consumer)
//   out_act / out_sum / out_ovf: ternary activation, final sum, limit flag
// Modports: master = producer/consumer side, slave = the neuron block.
// ---------------------------------------------------------------------------
interface ternary_neuron_seq_if #(
  parameter int ACC_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4:0]              in_pc_pos;
  logic [4:0]              in_pc_neg;
  logic                    in_last;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_act;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;

  modport master (
    output in_valid, in_pc_pos, in_pc_neg, in_last, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_pc_pos, in_pc_neg, in_last, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_ovf
  );
endinterface

// File: rtl/ternary_neuron_seq.sv
// ---------------------------------------------------------------------------
// ternary_neuron_seq
// Accumulates the signed difference of positive/negative popcounts over a
// variable number of beats, then thresholds the sum into a ternary
// activation (+1 = 2'b01, 0 = 2'b00, -1 = 2'b11) held until handed off.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : ternary_neuron_seq_if.slave (beat input, thresholds, result output)
//
// Parameters:
//   ACC_W      : signed accumulator / sum / threshold width (>= 6)
//   MAX_CHUNKS : beats after which a neuron is finalised without in_last
//
// Build option:
//   TNEURON_ACC_SAT_EN : when defined the per-beat sum saturates at the
//                        ACC_W signed rails; otherwise it wraps.
// ---------------------------------------------------------------------------
module ternary_neuron_seq #(
  parameter int ACC_W      = 10,
  parameter int MAX_CHUNKS = 16
) (
  input logic                 clk,
  input logic                 rst,
  ternary_neuron_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [1:0]              out_act_r;
  logic signed [ACC_W-1:0] out_sum_r;
  logic                    out_ovf_r;

  logic signed [6:0]       diff_s;
  logic signed [ACC_W-1:0] sum_next_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    cnt_hit_s;
  logic                    accept_s;
  logic                    finalize_s;
  logic [1:0]              act_s;

  // Threshold rule: +1 is checked first so it wins when the ranges overlap.
  function automatic logic [1:0] act_fn(
    input logic signed [ACC_W-1:0] sum,
    input logic signed [ACC_W-1:0] hi,
    input logic signed [ACC_W-1:0] lo
  );
    logic [1:0] act;
    if (sum >= hi) begin
      act = 2'b01;
    end else if (sum < lo) begin
      act = 2'b11;
    end else begin
      act = 2'b00;
    end
    return act;
  endfunction

  // Both popcounts are unsigned; two zero bits make them safe signed operands.
  assign diff_s = $signed({2'b00, bus.in_pc_pos}) - $signed({2'b00, bus.in_pc_neg});

`ifdef TNEURON_ACC_SAT_EN
  // Clamp a one-bit-wider sum back into the ACC_W signed range.
  function automatic logic signed [ACC_W-1:0] sat_fn(
    input logic signed [ACC_W:0] wide
  );
    logic signed [ACC_W-1:0] res;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) begin
        res = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      res = wide[ACC_W-1:0];
    end
    return res;
  endfunction

  logic signed [ACC_W:0] sum_wide_s;
  // One guard bit is enough: |diff| <= 31 never exceeds one ACC_W range.
  assign sum_wide_s = $signed({acc_r[ACC_W-1], acc_r}) + (ACC_W+1)'(diff_s);
  assign sum_next_s = sat_fn(sum_wide_s);
`else
  // Plain two's-complement wrap at ACC_W bits.
  assign sum_next_s = acc_r + ACC_W'(diff_s);
`endif

  assign cnt_inc_s = cnt_r + CNT_W'(1'b1);
  assign cnt_hit_s = (cnt_inc_s == CNT_W'(MAX_CHUNKS));
  assign act_s     = act_fn(sum_next_s, bus.thr_hi, bus.thr_lo);

  // in_ready depends only on state and rst, never on in_valid.
  assign bus.in_ready  = (state_r == ACCUM) && !rst;
  assign bus.out_valid = (state_r == DONE);
  assign bus.out_act   = out_act_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus beat accept / finalise strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finalize_s  = 1'b0;
    case (state_r)
      ACCUM: begin
        accept_s = bus.in_valid && !rst;
        if (accept_s && (bus.in_last || cnt_hit_s)) begin
          finalize_s  = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase
  end

  // Accumulator, beat counter and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      out_act_r <= 2'b00;
      out_sum_r <= '0;
      out_ovf_r <= 1'b0;
    end else if (finalize_s) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      out_act_r <= act_s;
      out_sum_r <= sum_next_s;
      out_ovf_r <= !bus.in_last;
    end else if (accept_s) begin
      acc_r     <= sum_next_s;
      cnt_r     <= cnt_inc_s;
      out_act_r <= out_act_r;
      out_sum_r <= out_sum_r;
      out_ovf_r <= out_ovf_r;
    end else begin
      acc_r     <= acc_r;
      cnt_r     <= cnt_r;
      out_act_r <= out_act_r;
      out_sum_r <= out_sum_r;
      out_ovf_r <= out_ovf_r;
    end
  end

endmodule

// File: tb/tb_ternary_neuron_seq.sv
// ---------------------------------------------------------------------------
// tb_ternary_neuron_seq
// Three instances: #0 default (ACC_W 10, MAX_CHUNKS 16), #1 MAX_CHUNKS 4,
// #2 ACC_W 6. An integer model predicts every cycle's in_ready, out_valid
// and held result; directed neurons pin the model with literal results.
// ---------------------------------------------------------------------------
module tb_ternary_neuron_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  // stimulus per instance
  int   pp [3];
  int   pn [3];
  int   th [3];
  int   tl [3];
  bit   iv [3];
  bit   il [3];
  bit   ordy [3];

  // DUT observations per instance
  logic       ir [3];
  logic       ov [3];
  logic [1:0] oa [3];
  logic       oo [3];
  int         os [3];

  // model state per instance
  bit         mv [3];
  int         ms [3];
  logic [1:0] ma [3];
  bit         mo [3];
  int         macc [3];
  int         mcnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 2) ? 6 : 10;
    localparam int MC = (g == 1) ? 4 : 16;
    ternary_neuron_seq_if #(.ACC_W(AW)) bus ();
    ternary_neuron_seq #(.ACC_W(AW), .MAX_CHUNKS(MC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.in_valid  = iv[g];
    assign bus.in_pc_pos = pp[g][4:0];
    assign bus.in_pc_neg = pn[g][4:0];
    assign bus.in_last   = il[g];
    assign bus.thr_hi    = th[g][AW-1:0];
    assign bus.thr_lo    = tl[g][AW-1:0];
    assign bus.out_ready = ordy[g];
    assign ir[g] = bus.in_ready;
    assign ov[g] = bus.out_valid;
    assign oa[g] = bus.out_act;
    assign oo[g] = bus.out_ovf;
    assign os[g] = int'(bus.out_sum);
  end

  function automatic int aw_of(input int g);
    return (g == 2) ? 6 : 10;
  endfunction

  function automatic int mc_of(input int g);
    return (g == 1) ? 4 : 16;
  endfunction

  // acc + diff in the integer domain, then saturate or wrap to aw bits
  function automatic int add_acc(input int a, input int d, input int aw);
    int s;
    int m;
    s = a + d;
    m = 1 << aw;
`ifdef TNEURON_ACC_SAT_EN
    if (s > m / 2 - 1) s = m / 2 - 1;
    else if (s < -(m / 2)) s = -(m / 2);
`else
    s = ((s % m) + m) % m;
    if (s > m / 2 - 1) s = s - m;
`endif
    return s;
  endfunction

  function automatic logic [1:0] act_of(input int s, input int hi, input int lo);
    if (s >= hi) return 2'b01;
    else if (s < lo) return 2'b11;
    else return 2'b00;
  endfunction

  task automatic chk(input string nm, input int g, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, g, got, want, $time);
    end
  endtask

  // behavioural model: one neuron result slot per instance
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        mv[g]   <= 1'b0;
        macc[g] <= 0;
        mcnt[g] <= 0;
      end else if (mv[g]) begin
        if (ordy[g]) mv[g] <= 1'b0;
      end else if (iv[g]) begin
        if (il[g] || (mcnt[g] + 1 == mc_of(g))) begin
          mv[g]   <= 1'b1;
          ms[g]   <= add_acc(macc[g], pp[g] - pn[g], aw_of(g));
          ma[g]   <= act_of(add_acc(macc[g], pp[g] - pn[g], aw_of(g)), th[g], tl[g]);
          mo[g]   <= !il[g];
          macc[g] <= 0;
          mcnt[g] <= 0;
        end else begin
          macc[g] <= add_acc(macc[g], pp[g] - pn[g], aw_of(g));
          mcnt[g] <= mcnt[g] + 1;
        end
      end
    end
  end

  // compare DUT against model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 3; g++) begin
        chk("in_ready", g, int'(ir[g]), int'(!mv[g] && !rst));
        chk("out_valid", g, int'(ov[g]), int'(mv[g]));
        if (mv[g]) begin
          chk("out_sum", g, os[g], ms[g]);
          chk("out_act", g, int'(oa[g]), int'(ma[g]));
          chk("out_ovf", g, int'(oo[g]), int'(mo[g]));
        end
      end
    end
  end

  // drive one beat; caller sits just after a rising edge
  task automatic beat(input int g, input int p, input int n, input bit l);
    bit took;
    took = 1'b0;
    iv[g] = 1'b1; pp[g] = p; pn[g] = n; il[g] = l;
    for (int k = 0; k < 64 && !took; k++) begin
      @(negedge clk);
      took = !mv[g] && !rst;
      @(posedge clk); #2;
    end
    iv[g] = 1'b0; il[g] = 1'b0;
    if (!took) begin
      total++; bad++;
      $display("FAIL beat_timeout[%0d] got=stuck want=accepted", g);
    end
  endtask

  // wait for a result, check it against literals, hold, then hand it off
  task automatic wait_res(input int g, input int es, input logic [1:0] ea,
                          input bit eo, input int lim, input int hold);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      seen = ov[g];
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL result_timeout[%0d] got=no_valid want=valid", g);
    end else begin
      chk("lit_sum", g, os[g], es);
      chk("lit_act", g, int'(oa[g]), int'(ea));
      chk("lit_ovf", g, int'(oo[g]), int'(eo));
      chk("model_sum", g, ms[g], es);
      chk("model_act", g, int'(ma[g]), int'(ea));
    end
    @(posedge clk); #2;
    repeat (hold) begin @(posedge clk); #2; end
    ordy[g] = 1'b1;
    @(posedge clk); #2;
    ordy[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      pp[g] = 0; pn[g] = 0; th[g] = 0; tl[g] = 0;
      iv[g] = 1'b0; il[g] = 1'b0; ordy[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    // reset values while rst is high
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_valid", g, int'(ov[g]), 0);
      chk("rst_sum", g, os[g], 0);
      chk("rst_act", g, int'(oa[g]), 0);
      chk("rst_ovf", g, int'(oo[g]), 0);
      chk("rst_ready", g, int'(ir[g]), 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 0, int'(ir[0]), 1);
    @(posedge clk); #2;

    // three-beat neuron, result one cycle after the last beat
    th[0] = 15; tl[0] = -5;
    beat(0, 20, 5, 1'b0);
    beat(0, 10, 12, 1'b0);
    beat(0, 7, 0, 1'b1);
    wait_res(0, 20, 2'b01, 1'b0, 1, 0);

    // single-beat neurons
    th[0] = 0; tl[0] = -10;
    beat(0, 3, 25, 1'b1);
    wait_res(0, -22, 2'b11, 1'b0, 1, 0);
    th[0] = 1; tl[0] = 0;
    beat(0, 12, 12, 1'b1);
    wait_res(0, 0, 2'b00, 1'b0, 1, 0);

    // chunk limit with backpressure; beat 5 waits and then opens a new neuron
    th[1] = 2; tl[1] = 0;
    for (int k = 0; k < 4; k++) beat(1, 1, 0, 1'b0);
    iv[1] = 1'b1; pp[1] = 1; pn[1] = 0; il[1] = 1'b0;
    wait_res(1, 4, 2'b01, 1'b1, 1, 10);
    @(negedge clk);
    chk("ready_after_handoff", 1, int'(ir[1]), 1);
    @(posedge clk); #2;
    iv[1] = 1'b0;
    beat(1, 0, 0, 1'b1);
    wait_res(1, 1, 2'b00, 1'b0, 1, 0);

    // narrow accumulator: saturate or wrap
    th[2] = 10; tl[2] = -10;
    for (int k = 0; k < 4; k++) beat(2, 31, 0, k == 3);
`ifdef TNEURON_ACC_SAT_EN
    wait_res(2, 31, 2'b01, 1'b0, 1, 0);
`else
    wait_res(2, -4, 2'b00, 1'b0, 1, 0);
`endif
    for (int k = 0; k < 3; k++) beat(2, 31, 0, 1'b0);
    beat(2, 0, 31, 1'b1);
`ifdef TNEURON_ACC_SAT_EN
    wait_res(2, 0, 2'b00, 1'b0, 1, 0);
`else
    wait_res(2, -2, 2'b00, 1'b0, 1, 0);
`endif

    // reset in the middle of a neuron discards the partial sum
    th[0] = 15; tl[0] = -5;
    beat(0, 5, 0, 1'b0);
    iv[0] = 1'b1; pp[0] = 5; pn[0] = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 0, int'(ir[0]), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 0, int'(ov[0]), 0);
    @(posedge clk); #2;
    beat(0, 4, 0, 1'b1);
    wait_res(0, 4, 2'b00, 1'b0, 1, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
